// File: rtl/mmu_bus_arbiter.sv
// Two-requester (I-fetch / load-store) arbiter for the shared D1 memory bus.
// Holds the grant for a whole burst; counts beats and releases on completion, error or claim drop.
module mmu_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  input  logic [DATA_WIDTH-1:0] I_WRITE_DATA,
  input  logic                  I_WRITE,
  input  logic [2:0]            I_SIZE,
  input  logic [2:0]            I_BURST,
  input  logic                  I_CLAIM,
  output logic [DATA_WIDTH-1:0] I_READ_DATA,
  output logic                  I_READYOUT,
  output logic                  I_RESP,
  output logic                  I_GNT,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [DATA_WIDTH-1:0] D_WRITE_DATA,
  input  logic                  D_WRITE,
  input  logic [2:0]            D_SIZE,
  input  logic [2:0]            D_BURST,
  input  logic                  D_CLAIM,
  output logic [DATA_WIDTH-1:0] D_READ_DATA,
  output logic                  D_READYOUT,
  output logic                  D_RESP,
  output logic                  D_GNT,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  output logic [DATA_WIDTH-1:0] M_WRITE_DATA,
  output logic                  M_WRITE,
  output logic [2:0]            M_SIZE,
  output logic [2:0]            M_BURST,
  output logic                  M_CLAIM,
  input  logic [DATA_WIDTH-1:0] M_READ_DATA,
  input  logic                  M_READYOUT,
  input  logic                  M_RESP
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam logic [4:0] MAX_BEATS = 5'd16;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [4:0] target_q, target_d;
  logic [4:0] count_q, count_d;

  logic       pick_d;
  logic       own_i, own_d;
  logic       own_claim;
  logic       beat_ok;
  logic [4:0] count_inc;

  // Beat target of 0 marks an unbounded INCR burst.
  function automatic logic [4:0] beat_target(input logic [2:0] burst);
    logic [4:0] t;
    case (burst)
      3'd0:       t = 5'd1;
      3'd1:       t = 5'd0;
      3'd2, 3'd3: t = 5'd4;
      3'd4, 3'd5: t = 5'd8;
      default:    t = 5'd16;
    endcase
    return t;
  endfunction

  assign own_i     = (state_q == OWN_I);
  assign own_d     = (state_q == OWN_D);
  assign own_claim = own_i ? I_CLAIM : D_CLAIM;
  assign beat_ok   = M_READYOUT & ~M_RESP;
  assign count_inc = (count_q == MAX_BEATS) ? count_q : count_q + 5'd1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    target_d = target_q;
    count_d  = count_q;
    pick_d   = D_CLAIM;

    if (I_CLAIM && D_CLAIM) begin
      if (FIXED_PRIORITY != 0) pick_d = PORT_D;
      else                     pick_d = (last_q == PORT_D) ? PORT_I : PORT_D;
    end

    case (state_q)
      IDLE: begin
        if (I_CLAIM || D_CLAIM) begin
          state_d  = (pick_d == PORT_D) ? OWN_D : OWN_I;
          target_d = beat_target((pick_d == PORT_D) ? D_BURST : I_BURST);
          count_d  = 5'd0;
          last_d   = pick_d;
        end
      end
      OWN_I, OWN_D: begin
        if (beat_ok) count_d = count_inc;
        // Leaving straight to IDLE guarantees a gap cycle between owners.
        if (M_RESP || !own_claim ||
            (beat_ok && (target_q != 5'd0) && (count_inc == target_q)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      last_q   <= PORT_D;
      target_q <= 5'd0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  assign M_ADDR       = own_i ? I_ADDR       : own_d ? D_ADDR       : '0;
  assign M_WRITE_DATA = own_i ? I_WRITE_DATA : own_d ? D_WRITE_DATA : '0;
  assign M_WRITE      = own_i ? I_WRITE      : own_d ? D_WRITE      : 1'b0;
  assign M_SIZE       = own_i ? I_SIZE       : own_d ? D_SIZE       : 3'd0;
  assign M_BURST      = own_i ? I_BURST      : own_d ? D_BURST      : 3'd0;
  assign M_CLAIM      = own_i ? I_CLAIM      : own_d ? D_CLAIM      : 1'b0;

  assign I_READ_DATA = own_i ? M_READ_DATA : '0;
  assign I_READYOUT  = own_i & M_READYOUT;
  assign I_RESP      = own_i & M_RESP;
  assign I_GNT       = own_i;

  assign D_READ_DATA = own_d ? M_READ_DATA : '0;
  assign D_READYOUT  = own_d & M_READYOUT;
  assign D_RESP      = own_d & M_RESP;
  assign D_GNT       = own_d;

endmodule

// File: doc/mmu_bus_arbiter.md
# mmu_bus_arbiter

Two-requester arbiter sharing the single D1 memory-side bus between the instruction-fetch cache (I port) and the load/store data path (D port). Sits between the pipeline's memory clients and the MMU, grants one owner at a time, and holds the grant for a whole burst. It also counts beats, propagates error responses to the owner only, and alternates ownership round-robin so neither side starves.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = D port always wins contention

Ports (X is I or D; each requester has an identical bundle):
- CLK  in  1  clock; all logic on posedge
- RSTN  in  1  synchronous, active-low reset
- X_ADDR  in  ADDR_WIDTH  requester address
- X_WRITE_DATA  in  DATA_WIDTH  requester write data
- X_WRITE  in  1  1 = write, 0 = read
- X_SIZE  in  3  transfer size (byte/half/word encoding of the MMU package)
- X_BURST  in  3  burst type: 0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16
- X_CLAIM  in  1  bus request; held high for the whole transfer
- X_READ_DATA  out  DATA_WIDTH  read data, valid only to the owner
- X_READYOUT  out  1  beat-complete/ready to the owner; 0 to non-owner
- X_RESP  out  1  error response to the owner; 0 to non-owner
- X_GNT  out  1  registered grant status
- M_ADDR, M_WRITE_DATA, M_WRITE, M_SIZE, M_BURST, M_CLAIM  out  (as above)  downstream MMU bus
- M_READ_DATA  in  DATA_WIDTH, M_READYOUT  in  1, M_RESP  in  1  downstream responses

## Operation
- States: IDLE, OWN_I, OWN_D. Registered grant; all M_* and X_* outputs are combinational muxes of the registered grant.
- IDLE: M_CLAIM=0, M_* address/control driven 0, X_READYOUT=0, X_RESP=0, X_READ_DATA=0.
- Arbitration in IDLE only. One claimant: grant it. Both claimants: FIXED_PRIORITY=1 grants D; otherwise grant the port not last served (pointer `last`, reset = D so I wins the first contention).
- On grant: latch beat target from owner's X_BURST (SINGLE=1, *4=4, *8=8, *16=16, INCR=unbounded). Clear 5-bit beat counter. Update `last`.
- OWN_x: M_* = owner's signals, owner receives M_READ_DATA/M_READYOUT/M_RESP directly; non-owner sees READYOUT=0, RESP=0, READ_DATA=0 (stalled).
- Beat accepted when M_READYOUT=1 and M_RESP=0; counter increments.
- Release to IDLE at the edge where: accepted beat makes count equal target; or M_RESP=1 (error aborts the burst); or owner drops X_CLAIM (INCR termination, early abort). For INCR, only CLAIM drop or RESP releases.
- No back-to-back grant: at least one IDLE cycle between owners; the same port may be re-granted after IDLE.
- Counter saturates at 16; the target never exceeds 16.

## Timing
- Reset (RSTN=0 at posedge): state IDLE, I_GNT=D_GNT=0, `last`=D, counter 0. All outputs 0 in the following cycle. Reset mid-burst aborts immediately; M_CLAIM drops the next cycle.
- Arbitration latency: claim seen at edge N, GNT=1 and M_CLAIM=1 from cycle N+1.
- Release: final beat accepted at edge N; GNT=0 and M_CLAIM=0 from N+1. The earliest next grant is visible at N+2.
- Error: M_RESP=1 sampled at edge N forwards to the owner combinationally in that cycle; IDLE from N+1.
- Simultaneous claim drop and final beat: single release, no extra beat counted.

## Test plan
- Single I read: I_CLAIM=1, BURST=0, ADDR=0x100; memory returns 0xDEADBEEF with READYOUT in cycle 2 -> I_READ_DATA=0xDEADBEEF, I_GNT 1 for cycles 1-2 only, M_ADDR=0x100.
- Contention round-robin: both claim WRAP4 continuously -> grant order I,D,I,D; each owns exactly 4 accepted beats; one IDLE cycle between owners; D_READYOUT=0 during I's burst.
- FIXED_PRIORITY=1: both claim -> D granted first and again after every release while D keeps claiming; I is granted only when D_CLAIM=0.
- Error abort: I WRAP8, M_RESP=1 on beat 3 -> I_RESP=1, D_RESP=0, grant released after 2 accepted beats, pending D granted two cycles later.
- INCR termination: D INCR, 6 beats then D_CLAIM=0 -> release the next cycle, counter shows 6, no further M_CLAIM.
- Reset mid-burst: RSTN=0 during beat 2 of I WRAP16 -> all outputs 0 the next cycle; after reset, simultaneous claims grant I first.
